c17_camo_key_resolver: RTL and testbench

// Oracle-guided decamouflaging engine for the c17 netlist whose gate driving N6 is camouflaged behind a 2-bit control key {s_1,s_0}.

---
 rtl/c17_camo_key_resolver_if.sv | 28 ++
 rtl/c17_camo_key_resolver.sv | 160 ++++++++++++++++
 tb/tb_c17_camo_key_resolver.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c17_camo_key_resolver_if.sv
// Query/response link between the key resolver and the oracle chip.
// master: resolver side (drives q_valid/q_pattern); slave: oracle side.
interface c17_camo_key_resolver_if;
    logic       q_valid;
    logic       q_ready;
    logic [4:0] q_pattern;
    logic       r_valid;
    logic       r_n10;
    logic       r_n11;

    modport master (
        output q_valid,
        output q_pattern,
        input  q_ready,
        input  r_valid,
        input  r_n10,
        input  r_n11
    );

    modport slave (
        input  q_valid,
        input  q_pattern,
        output q_ready,
        output r_valid,
        output r_n10,
        output r_n11
    );
endinterface

// File: rtl/c17_camo_key_resolver.sv
// Oracle-guided resolver for the camouflaged N6 gate of c17 (NAND/NOR/XOR).
// Ports: clk, rst_n, start, abort, bus (query/response), busy, done,
// ambiguous, error, s_0, s_1, cand {XOR,NOR,NAND}, n_queries.
module c17_camo_key_resolver #(
    parameter int MAX_QUERIES  = 32,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    c17_camo_key_resolver_if.master   bus,
    output logic                      busy,
    output logic                      done,
    output logic                      ambiguous,
    output logic                      error,
    output logic                      s_0,
    output logic                      s_1,
    output logic [2:0]                cand,
    output logic [5:0]                n_queries
);

    typedef enum logic [2:0] {
        IDLE, QUERY, WAIT, UPDATE, DONE, ERROR
    } state_t;

    localparam logic [5:0] QLAST = 6'(MAX_QUERIES);
    localparam logic [7:0] TLAST = 8'(RESP_TIMEOUT - 1);
    localparam logic       TOEN  = (RESP_TIMEOUT != 0);

    state_t     state;
    logic [4:0] pat;
    logic [7:0] wcnt;
    logic       q_vld;
    logic       rsp10;
    logic       rsp11;

    assign bus.q_valid   = q_vld;
    assign bus.q_pattern = pat;

    // c17 model of the latched pattern, one N10 prediction per candidate
    logic       n1, n2, n3, n4, n5;
    logic       n7, n8, n9, p11;
    logic       g_nand, g_nor, g_xor;
    logic [2:0] p10;
    logic [2:0] cand_nx;

    always_comb begin
        {n1, n2, n3, n4, n5} = pat;
        n8      = ~(n3 & n4);
        n7      = ~(n2 & n8);
        n9      = ~(n8 & n5);
        p11     = ~(n7 & n9);
        g_nand  = ~(n1 & n3);
        g_nor   = ~(n1 | n3);
        g_xor   = n1 ^ n3;
        p10     = {~(g_xor & n7), ~(g_nor & n7), ~(g_nand & n7)};
        cand_nx = cand & ~(p10 ^ {3{rsp10}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pat       <= '0;
            wcnt      <= '0;
            q_vld     <= 1'b0;
            rsp10     <= 1'b0;
            rsp11     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ambiguous <= 1'b0;
            error     <= 1'b0;
            s_0       <= 1'b0;
            s_1       <= 1'b0;
            cand      <= 3'b111;
            n_queries <= '0;
        end else if (abort) begin
            // result flags stay as they were; only the walk stops
            state <= IDLE;
            busy  <= 1'b0;
            q_vld <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state     <= QUERY;
                        cand      <= 3'b111;
                        n_queries <= '0;
                        pat       <= '0;
                        done      <= 1'b0;
                        ambiguous <= 1'b0;
                        error     <= 1'b0;
                        s_0       <= 1'b0;
                        s_1       <= 1'b0;
                        busy      <= 1'b1;
                        q_vld     <= 1'b1;
                    end
                end
                QUERY: begin
                    if (bus.q_ready) begin
                        q_vld <= 1'b0;
                        wcnt  <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.r_valid) begin
                        rsp10 <= bus.r_n10;
                        rsp11 <= bus.r_n11;
                        state <= UPDATE;
                    end else if (TOEN && wcnt == TLAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERROR;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                UPDATE: begin
                    if (p11 != rsp11) begin
                        // N11 does not depend on the key
                        cand  <= 3'b000;
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERROR;
                    end else begin
                        cand      <= cand_nx;
                        n_queries <= n_queries + 6'd1;
                        if (cand_nx == 3'b000) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= ERROR;
                        end else if ($onehot(cand_nx)) begin
                            done  <= 1'b1;
                            s_0   <= cand_nx[2];
                            s_1   <= cand_nx[1];
                            busy  <= 1'b0;
                            state <= DONE;
                        end else if (n_queries + 6'd1 == QLAST) begin
                            done      <= 1'b1;
                            ambiguous <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            pat   <= pat + 5'd1;
                            q_vld <= 1'b1;
                            state <= QUERY;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    q_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c17_camo_key_resolver.sv
// Scoreboard bench: directed oracle runs push expected results; monitors
// pop and compare whenever a resolver reaches DONE or ERROR.
module tb_c17_camo_key_resolver;

    typedef struct {
        bit       done;
        bit       amb;
        bit       err;
        bit       s0;
        bit       s1;
        bit [2:0] cand;
        bit [5:0] nq;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    res_t qa[$];
    res_t qb[$];

    // DUT A: default parameters
    logic       rst_a = 1'b0, start_a = 1'b0, abort_a = 1'b0;
    logic       busy_a, done_a, amb_a, err_a, s0_a, s1_a;
    logic [2:0] cand_a;
    logic [5:0] nq_a;
    c17_camo_key_resolver_if ifa ();

    c17_camo_key_resolver dut_a (
        .clk(clk), .rst_n(rst_a), .start(start_a), .abort(abort_a),
        .bus(ifa.master), .busy(busy_a), .done(done_a),
        .ambiguous(amb_a), .error(err_a), .s_0(s0_a), .s_1(s1_a),
        .cand(cand_a), .n_queries(nq_a)
    );

    // DUT B: short run and short timeout
    logic       rst_b = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic       busy_b, done_b, amb_b, err_b, s0_b, s1_b;
    logic [2:0] cand_b;
    logic [5:0] nq_b;
    c17_camo_key_resolver_if ifb ();

    c17_camo_key_resolver #(.MAX_QUERIES(4), .RESP_TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_b), .start(start_b), .abort(abort_b),
        .bus(ifb.master), .busy(busy_b), .done(done_b),
        .ambiguous(amb_b), .error(err_b), .s_0(s0_b), .s_1(s1_b),
        .cand(cand_b), .n_queries(nq_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference chip: key 0=NAND, 1=NOR, 2=XOR; returns {N10,N11}
    function automatic logic [1:0] chip(input int key, input logic [4:0] p);
        logic n1, n2, n3, n4, n5, n7, n8, n9, n11, g;
        {n1, n2, n3, n4, n5} = p;
        n8  = ~(n3 & n4);
        n7  = ~(n2 & n8);
        n9  = ~(n8 & n5);
        n11 = ~(n7 & n9);
        g   = (key == 0) ? ~(n1 & n3) : (key == 1) ? ~(n1 | n3) : (n1 ^ n3);
        return {~(g & n7), n11};
    endfunction

    // Oracle A controls
    int         key_a = 0, stall_a = 0;
    bit         inv_a = 0, mute_a = 0, inj_a = 0;

    initial begin
        int         st;
        logic [4:0] first, hp;
        logic [1:0] r;
        st = 0;
        ifa.q_ready = 0; ifa.r_valid = 0; ifa.r_n10 = 0; ifa.r_n11 = 0;
        forever begin
            @(negedge clk);
            ifa.r_valid = 0;
            if (inj_a) begin
                ifa.r_valid = 1;
                inj_a = 0;
            end
            if (ifa.q_ready) begin
                ifa.q_ready = 0;
                st = 0;
                if (!mute_a) begin
                    r = chip(key_a, hp);
                    ifa.r_n10 = r[1];
                    ifa.r_n11 = r[0] ^ (inv_a && hp == 5'd0);
                    ifa.r_valid = 1;
                end
            end else if (ifa.q_valid) begin
                if (st == 0) first = ifa.q_pattern;
                else chk("q_pattern_stable", ifa.q_pattern, first);
                if (st >= stall_a) begin
                    ifa.q_ready = 1;
                    hp = ifa.q_pattern;
                end
                st++;
            end
        end
    end

    // Oracle B: NAND chip, optionally silent
    bit mute_b = 0;

    initial begin
        logic [4:0] hp;
        logic [1:0] r;
        ifb.q_ready = 0; ifb.r_valid = 0; ifb.r_n10 = 0; ifb.r_n11 = 0;
        forever begin
            @(negedge clk);
            ifb.r_valid = 0;
            if (ifb.q_ready) begin
                ifb.q_ready = 0;
                if (!mute_b) begin
                    r = chip(0, hp);
                    ifb.r_n10 = r[1];
                    ifb.r_n11 = r[0];
                    ifb.r_valid = 1;
                end
            end else if (ifb.q_valid) begin
                ifb.q_ready = 1;
                hp = ifb.q_pattern;
            end
        end
    end

    task automatic cmp(input string tag, input res_t e, input res_t g);
        chk({tag, "_done"}, g.done, e.done);
        chk({tag, "_ambiguous"}, g.amb, e.amb);
        chk({tag, "_error"}, g.err, e.err);
        chk({tag, "_s_0"}, g.s0, e.s0);
        chk({tag, "_s_1"}, g.s1, e.s1);
        chk({tag, "_cand"}, g.cand, e.cand);
        chk({tag, "_n_queries"}, g.nq, e.nq);
    endtask

    // Monitors: compare on entry to DONE/ERROR
    initial begin
        bit   prev, fin;
        res_t g, e;
        prev = 0;
        forever begin
            @(negedge clk);
            fin = done_a | err_a;
            if (fin && !prev) begin
                g = '{done_a, amb_a, err_a, s0_a, s1_a, cand_a, nq_a};
                if (qa.size() == 0) chk("a_unexpected_result", 1, 0);
                else begin
                    e = qa.pop_front();
                    cmp("a", e, g);
                end
            end
            prev = fin;
        end
    end

    initial begin
        bit   prev, fin;
        res_t g, e;
        prev = 0;
        forever begin
            @(negedge clk);
            fin = done_b | err_b;
            if (fin && !prev) begin
                g = '{done_b, amb_b, err_b, s0_b, s1_b, cand_b, nq_b};
                if (qb.size() == 0) chk("b_unexpected_result", 1, 0);
                else begin
                    e = qb.pop_front();
                    cmp("b", e, g);
                end
            end
            prev = fin;
        end
    end

    task automatic run_a(input res_t e);
        bit ok;
        qa.push_back(e);
        @(negedge clk) start_a = 1;
        @(negedge clk) start_a = 0;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (!busy_a) ok = 1;
        end
        if (!ok) begin
            chk("a_run_bound", 0, 1);
            abort_a = 1;
            @(negedge clk) abort_a = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_b(input res_t e, output int wait_cyc);
        bit ok;
        wait_cyc = 0;
        qb.push_back(e);
        @(negedge clk) start_b = 1;
        @(negedge clk) start_b = 0;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (busy_b && !ifb.q_valid) wait_cyc++;
            @(negedge clk);
            if (!busy_b) ok = 1;
        end
        if (!ok) begin
            chk("b_run_bound", 0, 1);
            abort_b = 1;
            @(negedge clk) abort_b = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_ambiguous"}, amb_a, 0);
        chk({tag, "_error"}, err_a, 0);
        chk({tag, "_s"}, {s1_a, s0_a}, 0);
        chk({tag, "_cand"}, cand_a, 3'b111);
        chk({tag, "_n_queries"}, nq_a, 0);
        chk({tag, "_q_valid"}, ifa.q_valid, 0);
    endtask

    initial begin
        int wc;
        bit ok;
        repeat (3) @(negedge clk);
        chk_reset_a("reset_a");
        chk("reset_b_cand", cand_b, 3'b111);
        chk("reset_b_busy", busy_b, 0);
        rst_a = 1;
        rst_b = 1;
        @(negedge clk);

        // XOR chip resolves on pattern 0
        key_a = 2;
        run_a('{1, 0, 0, 1, 0, 3'b100, 6'd1});
        // NAND chip: pattern 0 drops XOR, pattern 4 drops NOR
        key_a = 0;
        run_a('{1, 0, 0, 0, 0, 3'b001, 6'd5});
        // NOR chip with a 3-cycle ready stall per query
        key_a = 1;
        stall_a = 3;
        run_a('{1, 0, 0, 0, 1, 3'b010, 6'd5});
        stall_a = 0;
        // N11 inverted on pattern 0
        key_a = 0;
        inv_a = 1;
        run_a('{0, 0, 1, 0, 0, 3'b000, 6'd0});
        inv_a = 0;

        // reset while waiting, then a stray response
        mute_a = 1;
        @(negedge clk) start_a = 1;
        @(negedge clk) start_a = 0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (busy_a && !ifa.q_valid) ok = 1;
        end
        chk("a_reach_wait", ok, 1);
        repeat (3) @(negedge clk);
        rst_a = 0;
        repeat (2) @(negedge clk);
        rst_a = 1;
        inj_a = 1;
        repeat (4) @(negedge clk);
        chk_reset_a("midrun_reset_a");
        mute_a = 0;
        key_a = 2;
        run_a('{1, 0, 0, 1, 0, 3'b100, 6'd1});

        // four queries against NAND leave NAND/NOR both alive
        run_b('{1, 1, 0, 0, 0, 3'b011, 6'd4}, wc);
        // silent oracle trips the 8-cycle timeout
        mute_b = 1;
        run_b('{0, 0, 1, 0, 0, 3'b111, 6'd0}, wc);
        chk("b_timeout_wait_cycles", wc, 8);
        mute_b = 0;

        repeat (3) @(negedge clk);
        chk("a_scoreboard_drained", qa.size(), 0);
        chk("b_scoreboard_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation did not end");
        $fatal(1);
    end

endmodule
